// File: rtl/muldiv_ctrl.sv
`timescale 1ns/1ps
// EX-stage multiply/divide sequencer: one op outstanding, drives the iterative div core,
// runs a fixed-latency multiply and strobes HI/LO back once. Stall is combinational.
module muldiv_ctrl #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic [1:0]            req_op_i,
  input  logic [DATA_W-1:0]     opa_i,
  input  logic [DATA_W-1:0]     opb_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  hilo_we_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  div_start_o,
  output logic                  div_annul_o,
  output logic                  div_signed_o,
  output logic [DATA_W-1:0]     div_opa_o,
  output logic [DATA_W-1:0]     div_opb_o,
  input  logic [2*DATA_W-1:0]   div_result_i,
  input  logic                  div_ready_i
);

  typedef enum logic [1:0] {IDLE, DIV_BUSY, MUL_BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   opa_q, opb_q, hi_q, lo_q;
  logic [3:0]          cnt_q;
  logic                accept;
  logic                mul_sgn;
  logic [2*DATA_W-1:0] ext_a, ext_b, mul_prod;

  assign accept = (state_q == IDLE) && req_valid_i && !flush_i;

  // Sign- or zero-extend to full width so one multiplier serves MULT and MULTU.
  assign mul_sgn  = (op_q == 2'b00);
  assign ext_a    = {{DATA_W{mul_sgn & opa_q[DATA_W-1]}}, opa_q};
  assign ext_b    = {{DATA_W{mul_sgn & opb_q[DATA_W-1]}}, opb_q};
  assign mul_prod = ext_a * ext_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    hilo_we_o   = 1'b0;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && !flush_i) begin
          stall_o = 1'b1;
          if (!req_op_i[1])        state_d = MUL_BUSY;
          else if (opb_i == '0)    state_d = DONE;
          else                     state_d = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (flush_i) begin
          div_annul_o = 1'b1;
          state_d     = IDLE;
        end else begin
          div_start_o = 1'b1;
          stall_o     = 1'b1;
          if (div_ready_i) state_d = DONE;
        end
      end
      MUL_BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          if (cnt_q == 4'd0) state_d = DONE;
        end
      end
      default: begin
        hilo_we_o = !flush_i;
        state_d   = IDLE;
      end
    endcase
    // Combinational outputs must read zero while reset is held, whatever the inputs do.
    if (rst) begin
      stall_o     = 1'b0;
      hilo_we_o   = 1'b0;
      div_start_o = 1'b0;
      div_annul_o = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (accept) begin
        op_q  <= req_op_i;
        opa_q <= opa_i;
        opb_q <= opb_i;
        cnt_q <= CNT_INIT;
        if (req_op_i[1] && (opb_i == '0)) begin
          hi_q <= opa_i;
          lo_q <= '1;
        end
      end
      if ((state_q == MUL_BUSY) && !flush_i) begin
        if (cnt_q == 4'd0) {hi_q, lo_q} <= mul_prod;
        else               cnt_q <= cnt_q - 4'd1;
      end
      if ((state_q == DIV_BUSY) && !flush_i && div_ready_i)
        {hi_q, lo_q} <= div_result_i;
    end
  end

  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign div_signed_o = (op_q == 2'b10);
  assign div_opa_o    = opa_q;
  assign div_opb_o    = opb_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for muldiv_ctrl: table of mul/div ops scored through a queue,
// plus hand sequences for flush, coincident ready/flush and async reset.
module tb_muldiv_ctrl;

  localparam int DW      = 32;
  localparam int MUL_LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [1:0]    req_op;
  logic [DW-1:0] opa, opb;
  logic          flush;
  logic          stall, hilo_we;
  logic [DW-1:0] hi, lo;
  logic          div_start, div_annul, div_signed;
  logic [DW-1:0] div_opa, div_opb;
  logic [2*DW-1:0] div_result;
  logic          div_ready;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  logic [DW-1:0] last_hi, last_lo;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    bit          scr;
  } vec_t;

  vec_t vecs[7];

  muldiv_ctrl #(.DATA_W(DW), .MUL_LAT(MUL_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_op_i     (req_op),
    .opa_i        (opa),
    .opb_i        (opb),
    .flush_i      (flush),
    .stall_o      (stall),
    .hilo_we_o    (hilo_we),
    .hi_o         (hi),
    .lo_o         (lo),
    .div_start_o  (div_start),
    .div_annul_o  (div_annul),
    .div_signed_o (div_signed),
    .div_opa_o    (div_opa),
    .div_opb_o    (div_opb),
    .div_result_i (div_result),
    .div_ready_i  (div_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural div core: computes from the operands the DUT presents.
  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 64'd0;
    if (sgn) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    return {a % b, a / b};
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int lat, input bit scr);
    bit done = 1'b0;
    logic [63:0] exp;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; opa = a; opb = b; flush = 1'b0; div_ready = 1'b0;
    sb_q.push_back({ehi, elo});
    for (int k = 0; k < 40 && !done; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (scr) begin opa = $urandom; opb = $urandom; end
        div_result = div_model(div_signed, div_opa, div_opb);
        div_ready  = div_start && (k == 3);
      end
      @(negedge clk);
      if (hilo_we) begin
        done = 1'b1;
        exp = sb_q.pop_front();
        chk("latency", 64'(k), 64'(lat));
        chk("stall_in_done", 64'(stall), 64'd0);
        chk("hi", 64'(hi), 64'(exp[63:32]));
        chk("lo", 64'(lo), 64'(exp[31:0]));
        last_hi = exp[63:32];
        last_lo = exp[31:0];
      end else begin
        chk("stall_busy", 64'(stall), 64'd1);
        if (op[1] && b == 32'd0) chk("div0_no_start", 64'(div_start), 64'd0);
      end
    end
    if (!done) begin
      chk("timeout_no_hilo_we", 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end
    @(posedge clk); #1;
    req_valid = 1'b0; div_ready = 1'b0;
    @(negedge clk);
    chk("no_rewrite", 64'(hilo_we), 64'd0);
    chk("idle_after_done", 64'(stall), 64'd0);
  endtask

  initial begin
    vecs[0] = '{2'b11, 32'd100,        32'd7,          32'd2,          32'd14,         4, 1'b0};
    vecs[1] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  4, 1'b1};
    vecs[2] = '{2'b00, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  MUL_LAT+1, 1'b1};
    vecs[3] = '{2'b01, 32'hFFFF_FFFF,  32'd3,          32'd2,          32'hFFFF_FFFD,  MUL_LAT+1, 1'b0};
    vecs[4] = '{2'b10, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1, 1'b0};
    vecs[5] = '{2'b11, 32'h8000_0000,  32'h10,         32'd0,          32'h0800_0000,  4, 1'b0};
    vecs[6] = '{2'b01, 32'h0001_0000,  32'h0001_0000,  32'd1,          32'd0,          MUL_LAT+1, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; opa = '0; opb = '0; flush = 1'b0;
    div_result = '0; div_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hilo_we", 64'(hilo_we), 64'd0);
    chk("rst_hi_lo", {hi, lo}, 64'd0);
    chk("rst_div_if", {30'd0, div_start, div_annul, div_opa}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat, vecs[i].scr);

    // Flush in the third DIV_BUSY cycle.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b11; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 3) flush = 1'b1;
      @(negedge clk);
      if (k < 3) chk("div_start_busy", 64'(div_start), 64'd1);
    end
    chk("flush_annul", 64'(div_annul), 64'd1);
    chk("flush_start", 64'(div_start), 64'd0);
    chk("flush_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("annul_one_cycle", 64'(div_annul), 64'd0);
    chk("flush_idle_stall", 64'(stall), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("flush_no_we", 64'(hilo_we), 64'd0);
    end

    // div_ready and flush coincide: flush wins, result discarded.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b10; opa = 32'hFFFF_FFF9; opb = 32'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1; div_ready = 1'b1; div_result = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    chk("coinc_annul", 64'(div_annul), 64'd1);
    chk("coinc_we", 64'(hilo_we), 64'd0);
    chk("coinc_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; div_ready = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("coinc_hi_lo_kept", {hi, lo}, {last_hi, last_lo});
    chk("coinc_idle", 64'(stall | hilo_we), 64'd0);

    // Flush arriving in DONE suppresses the write strobe.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b01; opa = 32'h0001_0000; opb = 32'h0001_0000;
    for (int k = 1; k <= MUL_LAT + 1; k++) begin
      @(posedge clk); #1;
      if (k == MUL_LAT + 1) flush = 1'b1;
    end
    @(negedge clk);
    chk("done_flush_we", 64'(hilo_we), 64'd0);
    chk("done_flush_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("done_flush_idle", 64'(stall | hilo_we), 64'd0);

    // Flushed request in IDLE is ignored.
    @(posedge clk); #1;
    req_valid = 1'b1; flush = 1'b1; req_op = 2'b11; opa = 32'd9; opb = 32'd3;
    @(negedge clk);
    chk("idle_flush_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_not_taken", 64'(stall), 64'd0);

    // Asynchronous reset in the middle of MUL_BUSY.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b00; opa = 32'hFFFF_FFFF; opb = 32'd3;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mul_busy_stall", 64'(stall), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_hi_lo", {hi, lo}, 64'd0);
    chk("arst_we_opa", {31'd0, hilo_we, div_opa}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("arst_no_we", 64'(hilo_we), 64'd0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd3, 32'd2, 32'hFFFF_FFFD, MUL_LAT + 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
